wrr_arbitor: RTL and testbench

//  Parametrised N-way weighted round-robin arbiter with a registered output FIFO.

---
 rtl/wrr_arbitor_pkg.sv | 14 +
 rtl/wrr_arbitor_if.sv | 25 ++
 rtl/wrr_arbitor_fifo.sv | 58 +++++
 rtl/wrr_arbitor.sv | 102 ++++++++++
 tb/tb_wrr_arbitor.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wrr_arbitor_pkg.sv
// Shared constants for the weighted round-robin arbiter and its users.
// Weight vectors pack channel 0 into the least significant nibble.
package wrr_arbitor_pkg;

  localparam int NUM_IN_DEF   = 4;
  localparam int WIDTH_DEF    = 32;
  localparam int DEPTH_DEF    = 4;
  localparam int WEIGHT_W_DEF = 4;

  // tarb gives channel 0 bursts of three; larb splits evenly in pairs.
  localparam logic [NUM_IN_DEF*WEIGHT_W_DEF-1:0] TARB_WEIGHTS = 16'h1113;
  localparam logic [NUM_IN_DEF*WEIGHT_W_DEF-1:0] LARB_WEIGHTS = 16'h2222;

endpackage

// File: rtl/wrr_arbitor_if.sv
// Upstream and downstream stream bundle of the weighted round-robin arbiter.
// Handshake: a beat moves on a cycle where valid && !stall; the sender holds valid and data while stalled.
interface wrr_arbitor_if #(
  parameter int NUM_IN = 4,
  parameter int WIDTH  = 32
);

  logic [NUM_IN-1:0]       valid_us;
  logic [NUM_IN*WIDTH-1:0] data_us;
  logic [NUM_IN-1:0]       stall_us;
  logic                    valid_ds;
  logic [WIDTH-1:0]        data_ds;
  logic                    stall_ds;

  modport master (
    output valid_us, data_us, stall_ds,
    input  stall_us, valid_ds, data_ds
  );

  modport slave (
    input  valid_us, data_us, stall_ds,
    output stall_us, valid_ds, data_ds
  );

endinterface

// File: rtl/wrr_arbitor_fifo.sv
// Registered synchronous FIFO; the head entry is presented whenever count_o is non-zero.
// Pushes into a full FIFO and pops from an empty one are ignored.
module arb_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic                       valid_o,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign do_push = push_i && (count_q != CW'(DEPTH));
  assign do_pop  = pop_i && (count_q != '0);

  // DEPTH is a power of two, so the pointers wrap by overflow.
  always_comb begin
    wr_d    = do_push ? wr_q + 1'b1 : wr_q;
    rd_d    = do_pop ? rd_q + 1'b1 : rd_q;
    count_d = count_q;
    if (do_push && !do_pop) count_d = count_q + 1'b1;
    if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

  assign valid_o = (count_q != '0);
  assign data_o  = mem_q[rd_q];
  assign count_o = count_q;

endmodule

// File: rtl/wrr_arbitor.sv
// N-way weighted round-robin arbiter feeding a registered output FIFO.
// A channel keeps the grant for up to its weight (0 counts as 1) back-to-back transfers.
module wrr_arbitor
  import wrr_arbitor_pkg::*;
#(
  parameter int NUM_IN   = NUM_IN_DEF,
  parameter int WIDTH    = WIDTH_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int WEIGHT_W = WEIGHT_W_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_IN*WEIGHT_W-1:0]   weights,
  wrr_arbitor_if.slave                 bus,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic [$clog2(NUM_IN)-1:0]    dbg_ptr_o,
  output logic [WEIGHT_W-1:0]          dbg_credit_o
);

  localparam int PTR_W = $clog2(NUM_IN);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [WEIGHT_W-1:0] credit_q, credit_d;
  logic [PTR_W-1:0]    grant;
  logic [PTR_W-1:0]    idx;
  logic                found;
  logic                accept;
  logic [NUM_IN-1:0]   stall;
  logic [WEIGHT_W-1:0] w_g, weff;
  logic [WEIGHT_W:0]   n;
  logic [CNT_W-1:0]    count;
  logic                fifo_valid;
  logic [WIDTH-1:0]    fifo_data;

  // First valid channel at or after ptr; the modulo keeps non-power-of-two NUM_IN correct.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      idx = PTR_W'((int'(ptr_q) + k) % NUM_IN);
      if (!found && bus.valid_us[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

  // Fullness uses the registered count so stall_ds never reaches stall_us combinationally.
  assign accept = !rst && found && (count < CNT_W'(DEPTH));

  always_comb begin
    stall = '1;
    if (accept) stall[grant] = 1'b0;
  end

  always_comb begin
    w_g  = weights[int'(grant)*WEIGHT_W +: WEIGHT_W];
    weff = (w_g == '0) ? WEIGHT_W'(1) : w_g;
    n    = (grant == ptr_q) ? {1'b0, credit_q} + (WEIGHT_W+1)'(1) : (WEIGHT_W+1)'(1);
    if (n < {1'b0, weff}) begin
      ptr_d    = grant;
      credit_d = n[WEIGHT_W-1:0];
    end else begin
      ptr_d    = (grant == PTR_W'(NUM_IN-1)) ? '0 : grant + PTR_W'(1);
      credit_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q    <= '0;
      credit_q <= '0;
    end else if (accept) begin
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
    end
  end

  arb_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (accept),
    .data_i  (bus.data_us[int'(grant)*WIDTH +: WIDTH]),
    .pop_i   (fifo_valid && !bus.stall_ds),
    .valid_o (fifo_valid),
    .data_o  (fifo_data),
    .count_o (count)
  );

  assign bus.stall_us  = stall;
  assign bus.valid_ds  = fifo_valid;
  assign bus.data_ds   = fifo_data;
  assign occupancy     = count;
  assign dbg_ptr_o     = ptr_q;
  assign dbg_credit_o  = credit_q;

endmodule

// File: tb/tb_wrr_arbitor.sv
// Bench for wrr_arbitor: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, and a long random ordering run.
module tb_wrr_arbitor;
  import wrr_arbitor_pkg::*;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int D  = 4;
  localparam int WW = 4;
  localparam int CW = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N*WW-1:0] weights;
  logic [CW-1:0]   occupancy;
  logic [1:0]      dbg_ptr;
  logic [WW-1:0]   dbg_credit;

  wrr_arbitor_if #(.NUM_IN(N), .WIDTH(W)) bus ();

  wrr_arbitor #(.NUM_IN(N), .WIDTH(W), .DEPTH(D), .WEIGHT_W(WW)) dut (
    .clk          (clk),
    .rst          (rst),
    .weights      (weights),
    .bus          (bus.slave),
    .occupancy    (occupancy),
    .dbg_ptr_o    (dbg_ptr),
    .dbg_credit_o (dbg_credit)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [N-1:0] m);
    idx_of = -1;
    for (int i = 0; i < N; i++) if (m[i] && idx_of < 0) idx_of = i;
  endfunction

  // reference model state
  bit           model_ok  = 1'b0;
  int           m_ptr     = 0;
  int           m_credit  = 0;
  logic [W-1:0] exp_q[$];
  logic [N-1:0] xfer_mask = '0;
  bit           rand_phase = 1'b0;
  int           in_seq[N];
  int           out_seq[N];
  int           wcnt[N];
  int           fair_bound = 0;

  always @(negedge clk) begin
    int g;
    bit acc;
    logic [N-1:0] exp_stall;
    int weff;
    int nn;
    int ch;
    if (model_ok) begin
      g = -1;
      for (int k = 0; k < N; k++)
        if (g < 0 && bus.valid_us[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      acc = !rst && (g >= 0) && (exp_q.size() < D);
      exp_stall = '1;
      if (acc) exp_stall[g] = 1'b0;

      chk("stall_us", 64'(bus.stall_us), 64'(exp_stall));
      chk("occupancy", 64'(occupancy), 64'(exp_q.size()));
      chk("valid_ds", 64'(bus.valid_ds), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) chk("data_ds", 64'(bus.data_ds), 64'(exp_q[0]));
      chk("ptr", 64'(dbg_ptr), 64'(m_ptr));
      chk("credit", 64'(dbg_credit), 64'(m_credit));

      xfer_mask = bus.valid_us & ~bus.stall_us;

      if (rand_phase && bus.valid_ds && !bus.stall_ds) begin
        ch = int'(bus.data_ds[31:24]);
        if (ch < N) begin
          chk("order", 64'(bus.data_ds[23:0]), 64'(out_seq[ch]));
          out_seq[ch]++;
        end else begin
          chk("order_ch", 64'(ch), 64'(0));
        end
      end

      if (rand_phase && acc) begin
        for (int i = 0; i < N; i++) begin
          if (i == g) begin
            chk("fair", 64'(wcnt[i] <= fair_bound), 64'(1));
            wcnt[i] = 0;
          end else if (bus.valid_us[i]) begin
            wcnt[i]++;
          end else begin
            wcnt[i] = 0;
          end
        end
      end

      if (rst) begin
        m_ptr = 0;
        m_credit = 0;
        exp_q.delete();
        for (int i = 0; i < N; i++) wcnt[i] = 0;
      end else begin
        if (exp_q.size() != 0 && !bus.stall_ds) void'(exp_q.pop_front());
        if (acc) begin
          exp_q.push_back(bus.data_us[g*W +: W]);
          weff = int'(weights[g*WW +: WW]);
          if (weff == 0) weff = 1;
          nn = (g == m_ptr) ? m_credit + 1 : 1;
          if (nn < weff) begin
            m_ptr = g;
            m_credit = nn;
          end else begin
            m_ptr = (g + 1) % N;
            m_credit = 0;
          end
        end
      end
    end else if (rst) begin
      model_ok = 1'b1;
      m_ptr = 0;
      m_credit = 0;
      exp_q.delete();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_data();
    for (int ch = 0; ch < N; ch++) bus.data_us[ch*W +: W] = {8'(ch), 24'(in_seq[ch])};
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.valid_us = '0;
    tick();
    rst = 1'b0;
  endtask

  int t2_exp[10] = '{0, 0, 0, 1, 2, 3, 0, 0, 0, 1};
  int t3_exp[5]  = '{0, 1, 2, 3, 0};
  int t4_ptr[4]  = '{0, 2, 3, 2};
  int t4_cr[4]   = '{0, 1, 0, 1};

  initial begin
    int cnt;
    int mw;
    weights = '0;
    bus.valid_us = '0;
    bus.stall_ds = 1'b0;
    for (int i = 0; i < N; i++) begin
      in_seq[i] = 0;
      out_seq[i] = 0;
      wcnt[i] = 0;
    end
    drive_data();
    repeat (2) tick();
    rst = 1'b0;

    // reset in the middle of a stream
    bus.stall_ds = 1'b1;
    bus.valid_us = 4'b0001;
    repeat (3) tick();
    bus.valid_us = '0;
    @(negedge clk);
    chk("t1_occ3", 64'(occupancy), 64'(3));
    chk("t1_valid", 64'(bus.valid_ds), 64'(1));
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.stall_ds = 1'b0;
    @(negedge clk);
    chk("t1_rst_valid", 64'(bus.valid_ds), 64'(0));
    chk("t1_rst_occ", 64'(occupancy), 64'(0));
    chk("t1_rst_ptr", 64'(dbg_ptr), 64'(0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t1_no_emit", 64'(bus.valid_ds), 64'(0));
    end

    // weighted bursts
    tick();
    do_reset();
    weights = TARB_WEIGHTS;
    bus.valid_us = '1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t2_grant", 64'(idx_of(~bus.stall_us)), 64'(t2_exp[i]));
      if (i == 1) chk("t2_latency", 64'(occupancy), 64'(1));
    end

    // zero weight behaves as one
    tick();
    do_reset();
    weights = '0;
    bus.valid_us = '1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_grant", 64'(idx_of(~bus.stall_us)), 64'(t3_exp[i]));
    end

    // only channel 2 valid, weight 2
    tick();
    do_reset();
    weights = 16'h0200;
    bus.valid_us = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t4_grant", 64'(idx_of(~bus.stall_us)), 64'(2));
      chk("t4_ptr", 64'(dbg_ptr), 64'(t4_ptr[i]));
      chk("t4_credit", 64'(dbg_credit), 64'(t4_cr[i]));
    end

    // backpressure
    tick();
    do_reset();
    weights = '0;
    bus.valid_us = '1;
    bus.stall_ds = 1'b1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.stall_us != '1) cnt++;
    end
    chk("t5_accepts", 64'(cnt), 64'(4));
    chk("t5_full_stall", 64'(bus.stall_us), 64'(4'hF));
    chk("t5_full_occ", 64'(occupancy), 64'(4));
    tick();
    bus.stall_ds = 1'b0;
    @(negedge clk);
    chk("t5_release_stall", 64'(bus.stall_us), 64'(4'hF));
    @(negedge clk);
    chk("t5_occ3", 64'(occupancy), 64'(3));
    chk("t5_resume", 64'(idx_of(~bus.stall_us)), 64'(0));

    // random traffic: ordering, completeness, fairness
    tick();
    do_reset();
    weights = 16'h2031;
    mw = 1;
    for (int i = 0; i < N; i++)
      if (int'(weights[i*WW +: WW]) > mw) mw = int'(weights[i*WW +: WW]);
    fair_bound = (N - 1) * mw;
    for (int i = 0; i < N; i++) begin
      in_seq[i] = 0;
      out_seq[i] = 0;
    end
    drive_data();
    rand_phase = 1'b1;
    for (int c = 0; c < 10060; c++) begin
      for (int ch = 0; ch < N; ch++) begin
        if (xfer_mask[ch]) begin
          in_seq[ch]++;
          bus.valid_us[ch] = (c < 10000) && ($urandom_range(0, 99) < 60);
        end else if (!bus.valid_us[ch]) begin
          bus.valid_us[ch] = (c < 10000) && ($urandom_range(0, 99) < 60);
        end
      end
      drive_data();
      bus.stall_ds = (c < 10000) && ($urandom_range(0, 99) < 30);
      tick();
    end
    @(negedge clk);
    for (int ch = 0; ch < N; ch++) chk("t6_complete", 64'(out_seq[ch]), 64'(in_seq[ch]));
    chk("t6_drained", 64'(occupancy), 64'(0));
    rand_phase = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
